// File: rtl/sram_result_reader_if.sv
// Handshake bundle for the result reader: control, SRAM read port and output stream.
interface sram_result_reader_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_csn;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, mem_rdata, out_ready,
    output busy, done, mem_csn, mem_wen, mem_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, mem_rdata, out_ready,
    input  busy, done, mem_csn, mem_wen, mem_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sram_result_reader.sv
// Streams COUNT words from SRAM starting at BASE_ADDR through a 2-entry output FIFO,
// issuing reads only when the FIFO plus the one in-flight read has room.
module sram_result_reader #(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BASE_ADDR = 262145,
  parameter int unsigned COUNT     = 260100,
  parameter int unsigned CNT_W     = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_result_reader_if.master  bus
);

  localparam logic [CNT_W-1:0]  COUNT_C = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              csn_q, csn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        level;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      csn_q      <= 1'b1;
      addr_q     <= BASE_C;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      csn_q      <= csn_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  // Next-state, issue decision and FIFO update
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    inflight_d = 1'b0;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    csn_d      = 1'b1;
    addr_d     = addr_q;
    issue      = 1'b0;

    pop   = valid_q & bus.out_ready;
    push  = inflight_q;
    level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = READ;
          issued_d   = '0;
          accepted_d = '0;
        end
      end
      READ: begin
        if (issued_q == COUNT_C) state_d = DRAIN;
        else if (level < 3'd2)   issue   = 1'b1;
      end
      DRAIN: begin
        // Leave as the last word is accepted so done follows it by one cycle
        if ((accepted_q == COUNT_C) || (pop && (accepted_q == LAST_C))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      csn_d      = 1'b0;
      addr_d     = BASE_C + ADDR_W'(issued_q);
      issued_d   = issued_q + CNT_W'(1);
      inflight_d = 1'b1;
    end

    if (pop) accepted_d = accepted_q + CNT_W'(1);

    // Shift FIFO: head_q is the visible word, tail_q the one behind it
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.mem_rdata;
        else               tail_d = bus.mem_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.mem_rdata;
        end else begin
          head_d = tail_q;
          tail_d = bus.mem_rdata;
        end
      end
      default: ;
    endcase

    valid_d = (occ_d != 2'd0);
    last_d  = valid_d && (accepted_d == LAST_C);
    busy_d  = (state_d == READ) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_csn   = csn_q;
  assign bus.mem_wen   = 1'b0;
  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = head_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_sram_result_reader.sv
// Directed bench for sram_result_reader: per-cycle vector tables plus reset, random-ready and single-word runs.
module tb_sram_result_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_result_reader_if #(.ADDR_W(19), .DATA_W(16)) if4 ();
  sram_result_reader_if #(.ADDR_W(19), .DATA_W(16)) if3 ();
  sram_result_reader_if #(.ADDR_W(19), .DATA_W(16)) if1 ();

  sram_result_reader #(.COUNT(4))    dut4 (.clk(clk), .rst(rst), .bus(if4));
  sram_result_reader #(.COUNT(1000)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  sram_result_reader #(.COUNT(1))    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Memory contents: each word equals the low 16 bits of its address
  assign if4.mem_rdata = if4.mem_addr[15:0];
  assign if3.mem_rdata = if3.mem_addr[15:0];
  assign if1.mem_rdata = if1.mem_addr[15:0];

  localparam logic [18:0] A = 19'h40001;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        start;
    logic        ready;
    logic        busy;
    logic        csn;
    logic [18:0] addr;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string tag, input logic st, input logic rd, input logic bz,
                              input logic cs, input logic [18:0] ad, input logic vl,
                              input logic [15:0] dt, input logic ls, input logic dn);
    vec_t v;
    v.tag = tag; v.start = st; v.ready = rd; v.busy = bz; v.csn = cs; v.addr = ad;
    v.valid = vl; v.data = dt; v.last = ls; v.done = dn;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row i: outputs expected in cycle i, inputs held during cycle i
  task automatic run_table();
    foreach (vecs[i]) begin
      step();
      check($sformatf("%s.busy", vecs[i].tag), 32'(if4.busy), 32'(vecs[i].busy));
      check($sformatf("%s.csn", vecs[i].tag), 32'(if4.mem_csn), 32'(vecs[i].csn));
      check($sformatf("%s.valid", vecs[i].tag), 32'(if4.out_valid), 32'(vecs[i].valid));
      check($sformatf("%s.last", vecs[i].tag), 32'(if4.out_last), 32'(vecs[i].last));
      check($sformatf("%s.done", vecs[i].tag), 32'(if4.done), 32'(vecs[i].done));
      check($sformatf("%s.wen", vecs[i].tag), 32'(if4.mem_wen), 32'(0));
      if (!vecs[i].csn)
        check($sformatf("%s.addr", vecs[i].tag), 32'(if4.mem_addr), 32'(vecs[i].addr));
      if (vecs[i].valid)
        check($sformatf("%s.data", vecs[i].tag), 32'(if4.out_data), 32'(vecs[i].data));
      if4.start     = vecs[i].start;
      if4.out_ready = vecs[i].ready;
    end
    vecs.delete();
  endtask

  // Full-speed 4-word run; the extra start fields let T4 pulse start mid-run
  task automatic add_t1(input string p, input logic s3, input logic s7);
    vecs.push_back(mk({p, "c0"}, 1, 1, 0, 1, '0,    0, '0,     0, 0));
    vecs.push_back(mk({p, "c1"}, 0, 1, 1, 1, '0,    0, '0,     0, 0));
    vecs.push_back(mk({p, "c2"}, 0, 1, 1, 0, A,     0, '0,     0, 0));
    vecs.push_back(mk({p, "c3"}, s3, 1, 1, 0, A + 1, 1, 16'h1, 0, 0));
    vecs.push_back(mk({p, "c4"}, 0, 1, 1, 0, A + 2, 1, 16'h2,  0, 0));
    vecs.push_back(mk({p, "c5"}, 0, 1, 1, 0, A + 3, 1, 16'h3,  0, 0));
    vecs.push_back(mk({p, "c6"}, 0, 1, 1, 1, '0,    1, 16'h4,  1, 0));
    vecs.push_back(mk({p, "c7"}, s7, 1, 0, 1, '0,   0, '0,     0, 1));
    vecs.push_back(mk({p, "c8"}, 0, 1, 0, 1, '0,    0, '0,     0, 0));
  endtask

  task automatic add_t2();
    vecs.push_back(mk("T2c0",  1, 1, 0, 1, '0,    0, '0,    0, 0));
    vecs.push_back(mk("T2c1",  0, 1, 1, 1, '0,    0, '0,    0, 0));
    vecs.push_back(mk("T2c2",  0, 1, 1, 0, A,     0, '0,    0, 0));
    vecs.push_back(mk("T2c3",  0, 1, 1, 0, A + 1, 1, 16'h1, 0, 0));
    vecs.push_back(mk("T2c4",  0, 0, 1, 0, A + 2, 1, 16'h2, 0, 0));
    vecs.push_back(mk("T2c5",  0, 0, 1, 1, '0,    1, 16'h2, 0, 0));
    vecs.push_back(mk("T2c6",  0, 0, 1, 1, '0,    1, 16'h2, 0, 0));
    vecs.push_back(mk("T2c7",  0, 0, 1, 1, '0,    1, 16'h2, 0, 0));
    vecs.push_back(mk("T2c8",  0, 1, 1, 1, '0,    1, 16'h2, 0, 0));
    vecs.push_back(mk("T2c9",  0, 1, 1, 0, A + 3, 1, 16'h3, 0, 0));
    vecs.push_back(mk("T2c10", 0, 1, 1, 1, '0,    1, 16'h4, 1, 0));
    vecs.push_back(mk("T2c11", 0, 1, 0, 1, '0,    0, '0,    0, 1));
    vecs.push_back(mk("T2c12", 0, 1, 0, 1, '0,    0, '0,    0, 0));
  endtask

  initial begin
    logic        wen_seen;
    logic        hold_pending;
    logic [33:0] held;
    logic        rdy;
    int          words, dones, post, t5_dones;

    if4.start = 0; if4.out_ready = 0;
    if3.start = 0; if3.out_ready = 0;
    if1.start = 0; if1.out_ready = 0;

    // Reset values
    step(); step();
    check("rst.busy",  32'(if4.busy),      32'(0));
    check("rst.done",  32'(if4.done),      32'(0));
    check("rst.csn",   32'(if4.mem_csn),   32'(1));
    check("rst.wen",   32'(if4.mem_wen),   32'(0));
    check("rst.addr",  32'(if4.mem_addr),  32'(A));
    check("rst.valid", 32'(if4.out_valid), 32'(0));
    check("rst.last",  32'(if4.out_last),  32'(0));
    check("rst.data",  32'(if4.out_data),  32'(0));
    rst = 1'b0;

    // T1, T2, T4 (start during busy and DONE ignored, then a full second run)
    add_t1("T1", 0, 0);
    add_t2();
    add_t1("T4", 1, 1);
    vecs.push_back(mk("T4c9",  0, 1, 0, 1, '0, 0, '0, 0, 0));
    vecs.push_back(mk("T4c10", 0, 1, 0, 1, '0, 0, '0, 0, 0));
    add_t1("T4b", 0, 0);
    run_table();

    // T5: reset after two words accepted
    if4.out_ready = 1;
    step(); if4.start = 1;
    step(); if4.start = 0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("T5.busy",  32'(if4.busy),      32'(0));
    check("T5.done",  32'(if4.done),      32'(0));
    check("T5.csn",   32'(if4.mem_csn),   32'(1));
    check("T5.addr",  32'(if4.mem_addr),  32'(A));
    check("T5.valid", 32'(if4.out_valid), 32'(0));
    check("T5.last",  32'(if4.out_last),  32'(0));
    check("T5.data",  32'(if4.out_data),  32'(0));
    step(); step();
    rst = 1'b0;
    t5_dones = 0;
    repeat (6) begin
      step();
      if (if4.done) t5_dones++;
    end
    check("T5.no_done", 32'(t5_dones), 32'(0));
    check("T5.idle",    32'(if4.busy), 32'(0));
    add_t1("T5r", 0, 0);
    run_table();

    // T3: random ready, 1000 words
    step(); if3.start = 1;
    step(); if3.start = 0;
    words = 0; dones = 0; post = 0; hold_pending = 0; held = '0;
    for (int cyc = 0; cyc < 20000 && post < 10; cyc++) begin
      step();
      if (hold_pending)
        check("T3.hold", 32'({if3.out_valid, if3.out_last, if3.out_data}), 32'(held));
      if (if3.done) dones++;
      rdy = 1'($urandom_range(0, 1));
      if3.out_ready = rdy;
      if (if3.out_valid && rdy) begin
        check("T3.data", 32'(if3.out_data), 32'(16'(32'h40001 + words)));
        check("T3.last", 32'(if3.out_last), 32'(words == 999));
        words++;
      end
      hold_pending = if3.out_valid && !rdy;
      held = 34'({if3.out_valid, if3.out_last, if3.out_data});
      if (words >= 1000) post++;
    end
    check("T3.words", 32'(words), 32'(1000));
    check("T3.dones", 32'(dones), 32'(1));
    if3.out_ready = 0;

    // T6: single-word run
    if1.out_ready = 1;
    wen_seen = 0;
    step(); wen_seen |= if1.mem_wen;
    check("T6.idle", 32'(if1.busy), 32'(0));
    if1.start = 1;
    step(); wen_seen |= if1.mem_wen;
    if1.start = 0;
    check("T6.busy", 32'(if1.busy), 32'(1));
    step(); wen_seen |= if1.mem_wen;
    check("T6.csn",  32'(if1.mem_csn),  32'(0));
    check("T6.addr", 32'(if1.mem_addr), 32'(A));
    step(); wen_seen |= if1.mem_wen;
    check("T6.valid", 32'(if1.out_valid), 32'(1));
    check("T6.data",  32'(if1.out_data),  32'(16'h1));
    check("T6.last",  32'(if1.out_last),  32'(1));
    step(); wen_seen |= if1.mem_wen;
    check("T6.done",   32'(if1.done),      32'(1));
    check("T6.valid0", 32'(if1.out_valid), 32'(0));
    check("T6.busy0",  32'(if1.busy),      32'(0));
    step(); wen_seen |= if1.mem_wen;
    check("T6.done0", 32'(if1.done), 32'(0));
    check("T6.wen",   32'(wen_seen), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
